// File: rtl/alu_pkg.sv
// Shared definitions for the digit-serial ALU: opcodes, FSM encoding and
// the per-opcode carry/operand rules used by both the top and the slice.
package alu_pkg;

   localparam logic [2:0] OP_INC = 3'b000;
   localparam logic [2:0] OP_ADD = 3'b001;
   localparam logic [2:0] OP_SUB = 3'b010;
   localparam logic [2:0] OP_DEC = 3'b011;
   localparam logic [2:0] OP_AND = 3'b100;
   localparam logic [2:0] OP_OR  = 3'b101;
   localparam logic [2:0] OP_XOR = 3'b110;
   localparam logic [2:0] OP_NOT = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Carry fed into digit 0: SUB and INC add one, DEC adds all-ones with no carry.
   function automatic logic init_carry(input logic [2:0] op, input logic cin);
      case (op)
         OP_ADD:         return cin;
         OP_SUB, OP_INC: return 1'b1;
         default:        return 1'b0;
      endcase
   endfunction

   function automatic logic is_arith(input logic [2:0] op);
      return ~op[2];
   endfunction

   // Sign of the B operand as actually presented to the adder.
   function automatic logic b_sign_eff(input logic [2:0] op, input logic b_msb);
      case (op)
         OP_SUB:  return ~b_msb;
         OP_DEC:  return 1'b1;
         OP_INC:  return 1'b0;
         default: return b_msb;
      endcase
   endfunction

endpackage

// File: rtl/alu_digit_slice.sv
// Combinational DIGIT-wide ALU slice; all eight operations, carry in/out
// for the arithmetic group, carry_out forced low for logic operations.
module alu_digit_slice
   import alu_pkg::*;
#(
   parameter int DIGIT = 4
) (
   input  logic [DIGIT-1:0] a_d,
   input  logic [DIGIT-1:0] b_d,
   input  logic [2:0]       op,
   input  logic             carry_in,
   output logic [DIGIT-1:0] f_d,
   output logic             carry_out
);

   logic [DIGIT-1:0] b_eff;
   logic [DIGIT:0]   sum;

   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
      b_eff     = b_d;
      sum       = '0;
      f_d       = '0;
      carry_out = 1'b0;

      case (op)
         OP_SUB:  b_eff = ~b_d;
         OP_DEC:  b_eff = '1;
         OP_INC:  b_eff = '0;
         default: b_eff = b_d;
      endcase

      sum = {1'b0, a_d} + {1'b0, b_eff} + {{DIGIT{1'b0}}, carry_in};

      case (op)
         OP_AND: f_d = a_d & b_d;
         OP_OR:  f_d = a_d | b_d;
         OP_XOR: f_d = a_d ^ b_d;
         OP_NOT: f_d = ~a_d;
         default: begin
            f_d       = sum[DIGIT-1:0];
            carry_out = sum[DIGIT];
         end
      endcase
   end

endmodule

// File: rtl/alu_digit_serial.sv
// Digit-serial ALU: WIDTH-bit operands processed DIGIT bits per clock, LSB first,
// with valid/ready handshakes. Define ALU_FLAGS_EN to build the {ovf, neg, zero} flags.
module alu_digit_serial
   import alu_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic [2:0]       flags
);

   localparam int N     = WIDTH / DIGIT;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   generate
      if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
         $error("alu_digit_serial: WIDTH (%0d) must be a multiple of DIGIT (%0d)", WIDTH, DIGIT);
      end
   endgenerate

   state_t           state, state_nx;
   logic [WIDTH-1:0] a_r, b_r, result_r;
   logic [2:0]       op_r;
   logic             carry_r, cout_r;
   logic [CNT_W-1:0] cnt;
   logic [IDX_W-1:0] base;
   logic             accept, last_digit;
   logic [DIGIT-1:0] f_d;
   logic             carry_out;

   assign in_ready   = (state == S_IDLE);
   assign out_valid  = (state == S_DONE);
   assign accept     = in_valid && in_ready;
   assign last_digit = (cnt == CNT_W'(N - 1));
   assign base       = IDX_W'(int'(cnt) * DIGIT);
   assign result     = result_r;
   assign cout       = cout_r;

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking <= so every register sees pre-edge values.
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (accept)     state_nx = S_BUSY;
         S_BUSY:  if (last_digit) state_nx = S_DONE;
         S_DONE:  if (out_ready)  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // One shared slice; the digit index selects which operand bits it sees.
   alu_digit_slice #(.DIGIT(DIGIT)) u_slice (
      .a_d       (a_r[base +: DIGIT]),
      .b_d       (b_r[base +: DIGIT]),
      .op        (op_r),
      .carry_in  (carry_r),
      .f_d       (f_d),
      .carry_out (carry_out)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         a_r      <= '0;
         b_r      <= '0;
         op_r     <= '0;
         result_r <= '0;
         carry_r  <= 1'b0;
         cout_r   <= 1'b0;
         cnt      <= '0;
      end else if (accept) begin
         a_r     <= a;
         b_r     <= b;
         op_r    <= op;
         carry_r <= init_carry(op, cin);
         cnt     <= '0;
      end else if (state == S_BUSY) begin
         result_r[base +: DIGIT] <= f_d;
         carry_r                 <= carry_out;
         cnt                     <= cnt + CNT_W'(1);
         if (last_digit) cout_r <= carry_out;
      end
   end

`ifdef ALU_FLAGS_EN
   logic [WIDTH-1:0] res_nx;
   logic [2:0]       flags_nx, flags_r;
   logic             ovf;

   // Flags are taken from the result as it will look after the final digit lands.
   always_comb begin
      res_nx              = result_r;
      res_nx[base +: DIGIT] = f_d;
      ovf = is_arith(op_r)
            && (a_r[WIDTH-1] == b_sign_eff(op_r, b_r[WIDTH-1]))
            && (res_nx[WIDTH-1] != a_r[WIDTH-1]);
      flags_nx = {ovf, res_nx[WIDTH-1], (res_nx == '0)};
   end

   always_ff @(posedge clk) begin
      if (rst)                                flags_r <= 3'b000;
      else if (state == S_BUSY && last_digit) flags_r <= flags_nx;
   end

   assign flags = flags_r;
`else
   assign flags = 3'b000;
`endif

endmodule

// File: tb/tb_alu_digit_serial.sv
// Directed bench for alu_digit_serial (WIDTH=16, DIGIT=4) with an arithmetic
// reference model and a per-cycle output compare process.
module tb_alu_digit_serial;
   import alu_pkg::*;

   localparam int WIDTH = 16;
   localparam int DIGIT = 4;
   localparam int N     = WIDTH / DIGIT;
`ifdef ALU_FLAGS_EN
   localparam logic [2:0] FLAG_MASK = 3'b111;
`else
   localparam logic [2:0] FLAG_MASK = 3'b000;
`endif

   typedef struct {
      logic [WIDTH-1:0] result;
      logic             cout;
      logic [2:0]       flags;
   } exp_t;

   logic             clk, rst, in_valid, in_ready, out_valid, out_ready, cin, cout;
   logic [2:0]       op, flags;
   logic [WIDTH-1:0] a, b, result;

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t exp_q[$];
   logic [WIDTH-1:0] got_res;
   logic             got_cout;
   logic [2:0]       got_flags;

   alu_digit_serial #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .cout      (cout),
      .flags     (flags)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic; overflow is the signed result leaving range.
   function automatic exp_t model(input logic [2:0] o, input logic [WIDTH-1:0] x,
                                  input logic [WIDTH-1:0] y, input logic c);
      exp_t        e;
      int          sx, sy, sres;
      logic [WIDTH:0] full;
      logic        arith, ovf;
      sx    = int'($signed(x));
      sy    = int'($signed(y));
      sres  = 0;
      full  = '0;
      arith = 1'b1;
      e.cout = 1'b0;
      case (o)
         OP_INC: begin full = {1'b0, x} + 17'd1;                   e.cout = full[WIDTH]; sres = sx + 1; end
         OP_ADD: begin full = {1'b0, x} + {1'b0, y} + {16'd0, c};  e.cout = full[WIDTH]; sres = sx + sy + int'(c); end
         OP_SUB: begin full = {1'b0, x} - {1'b0, y};               e.cout = (x >= y);    sres = sx - sy; end
         OP_DEC: begin full = {1'b0, x} - 17'd1;                   e.cout = (x != 0);    sres = sx - 1; end
         OP_AND: begin full = {1'b0, x & y}; arith = 1'b0; end
         OP_OR:  begin full = {1'b0, x | y}; arith = 1'b0; end
         OP_XOR: begin full = {1'b0, x ^ y}; arith = 1'b0; end
         default: begin full = {1'b0, ~x};   arith = 1'b0; end
      endcase
      e.result = full[WIDTH-1:0];
      ovf      = arith && (sres > 32767 || sres < -32768);
      e.flags  = {ovf, e.result[WIDTH-1], (e.result == 0)} & FLAG_MASK;
      return e;
   endfunction

   always @(negedge clk) begin
      if (out_valid) begin
         if (exp_q.size() == 0) begin
            check("spurious_out_valid", 32'(out_valid), 32'd0);
         end else begin
            check("result", 32'(result), 32'(exp_q[0].result));
            check("cout",   32'(cout),   32'(exp_q[0].cout));
            check("flags",  32'(flags),  32'(exp_q[0].flags));
            if (out_ready) void'(exp_q.pop_front());
         end
      end
   end

   task automatic run_op(input logic [2:0] o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                         input logic c, input int stall, input bit hold_valid);
      int cyc;
      check("in_ready_idle", 32'(in_ready), 32'd1);
      in_valid  = 1'b1;
      op        = o;
      a         = x;
      b         = y;
      cin       = c;
      out_ready = 1'b0;
      exp_q.push_back(model(o, x, y, c));
      @(posedge clk); #1;
      if (!hold_valid) in_valid = 1'b0;
      check("in_ready_busy", 32'(in_ready), 32'd0);
      cyc = 0;
      while (!out_valid && cyc < 4 * N + 10) begin
         @(posedge clk); #1;
         cyc++;
      end
      in_valid = 1'b0;
      check("latency", 32'(cyc), 32'(N));
      got_res   = result;
      got_cout  = cout;
      got_flags = flags;
      repeat (stall) begin
         @(posedge clk); #1;
         check("stall_out_valid", 32'(out_valid), 32'd1);
         check("stall_in_ready",  32'(in_ready),  32'd0);
         check("stall_result",    32'(result),    32'(got_res));
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("out_valid_drop", 32'(out_valid), 32'd0);
      check("in_ready_back",  32'(in_ready),  32'd1);
   endtask

   task automatic lit(input string name, input logic [WIDTH-1:0] r, input logic co, input logic [2:0] f);
      check({name, "_res"},   32'(got_res),   32'(r));
      check({name, "_cout"},  32'(got_cout),  32'(co));
      check({name, "_flags"}, 32'(got_flags), 32'(f & FLAG_MASK));
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
      op = OP_ADD; a = 16'h1111; b = 16'h2222; cin = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready",  32'(in_ready),  32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_result",    32'(result),    32'd0);
      check("rst_cout",      32'(cout),      32'd0);
      check("rst_flags",     32'(flags),     32'd0);
      rst = 1'b0; in_valid = 1'b0;

      run_op(OP_ADD, 16'h7FFF, 16'h0001, 1'b0, 0, 1'b0); lit("add_ovf",  16'h8000, 1'b0, 3'b110);
      run_op(OP_SUB, 16'h0003, 16'h0005, 1'b0, 0, 1'b0); lit("sub_brw",  16'hFFFE, 1'b0, 3'b010);
      run_op(OP_SUB, 16'h0005, 16'h0005, 1'b0, 0, 1'b0); lit("sub_eq",   16'h0000, 1'b1, 3'b001);
      run_op(OP_INC, 16'hFFFF, 16'h1234, 1'b1, 0, 1'b0); lit("inc_wrap", 16'h0000, 1'b1, 3'b001);
      run_op(OP_DEC, 16'h8000, 16'h5555, 1'b1, 0, 1'b0); lit("dec_ovf",  16'h7FFF, 1'b1, 3'b100);
      run_op(OP_XOR, 16'hF0F0, 16'hFF00, 1'b1, 0, 1'b0); lit("xor",      16'h0FF0, 1'b0, 3'b000);
      run_op(OP_NOT, 16'h00FF, 16'hAAAA, 1'b1, 0, 1'b1); lit("not_hold", 16'hFF00, 1'b0, 3'b010);
      run_op(OP_ADD, 16'h1234, 16'h0FFF, 1'b1, 0, 1'b0); lit("add_cin",  16'h2234, 1'b0, 3'b000);
      run_op(OP_AND, 16'hA5A5, 16'h0FF0, 1'b1, 0, 1'b0); lit("and",      16'h05A0, 1'b0, 3'b000);
      run_op(OP_OR,  16'h1200, 16'h0034, 1'b0, 0, 1'b0); lit("or",       16'h1234, 1'b0, 3'b000);
      run_op(OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 0, 1'b0); lit("add_cy",   16'h0000, 1'b1, 3'b001);
      run_op(OP_ADD, 16'h1000, 16'h2000, 1'b0, 5, 1'b0); lit("bp",       16'h3000, 1'b0, 3'b000);

      // Abort: reset lands in the second BUSY cycle, with in_valid high during reset.
      check("abort_in_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b1; op = OP_ADD; a = 16'h0F0F; b = 16'h0101; cin = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      exp_q.delete();
      check("abort_out_valid", 32'(out_valid), 32'd0);
      check("abort_result",    32'(result),    32'd0);
      check("abort_in_ready",  32'(in_ready),  32'd1);
      check("abort_cout",      32'(cout),      32'd0);
      check("abort_flags",     32'(flags),     32'd0);
      rst = 1'b0; in_valid = 1'b0;
      @(posedge clk); #1;
      check("abort_no_accept", 32'(in_ready), 32'd1);
      run_op(OP_ADD, 16'h0001, 16'h0001, 1'b0, 0, 1'b0); lit("post_rst", 16'h0002, 1'b0, 3'b000);

      repeat (3) @(posedge clk);
      #1;
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_digit_serial.md
Name: alu_digit_serial

Overview:
- Parametrised, multi-cycle successor to the single-bit ALU slice; keeps the same 8-operation set and 3-bit opcode.
- Processes a WIDTH-bit operand pair DIGIT bits per clock through one shared combinational digit slice, with a registered carry chain between digits.
- Valid/ready handshake on input and output, so it drops into the datapath between operand registers and the writeback stage.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of DIGIT (elaboration-time error otherwise).
- DIGIT, 4, bits processed per cycle; DIGIT == WIDTH gives single-pass operation.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands and opcode valid.
- in_ready  out  1  block can accept a new operation.
- op  in  3  opcode: 000 INC A, 001 ADD, 010 SUB, 011 DEC A, 100 AND, 101 OR, 110 XOR, 111 NOT A.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B (ignored for INC, DEC, NOT).
- cin  in  1  carry-in; used by ADD only.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  operation result.
- cout  out  1  carry out of the MSB digit; 0 for logic ops.
- flags  out  3  {overflow, negative, zero}.

Behaviour:
- Reset: state IDLE; in_ready=1, out_valid=0, result=0, cout=0, flags=0; digit counter and carry register cleared.
- FSM states: IDLE, BUSY, DONE.
- IDLE -> BUSY on in_valid && in_ready. a, b, op and cin are captured on that edge, and the initial carry is set:
  - ADD: cin
  - SUB: 1 (A + ~B + 1)
  - INC: 1 (A + 0 + 1)
  - DEC: 0 (A + all-ones + 0)
  - logic ops: 0
- BUSY: each edge processes digit k (LSB first, k = 0..N-1, N = WIDTH/DIGIT), writes result[k*DIGIT +: DIGIT] and updates the carry register.
- BUSY -> DONE on the edge that processes digit N-1. out_valid therefore rises exactly N clocks after the accept edge.
- DONE: result, cout and flags are held stable while out_valid=1 && out_ready=0. DONE -> IDLE on out_ready.
- in_ready is 1 only in IDLE; in_valid is ignored in BUSY and DONE. No overlap, so throughput is one op per N+2 cycles under continuous ready.
- Arithmetic is modulo 2^WIDTH.
- cout is the carry out of the final digit. For SUB, cout=1 means no borrow (a >= b unsigned).
- zero = (result == 0).
- negative = result[WIDTH-1].
- overflow is two's-complement signed overflow:
  - ADD/INC: operand signs equal and result sign differs.
  - SUB: a and b signs differ and result sign differs from a.
  - DEC: a = 100..0 -> 011..1 sets overflow.
  - logic ops: overflow = 0.
- rst asserted in any state aborts the operation at the next edge with full reset values; a partially computed result is discarded.
- Any in_valid seen during the rst cycle is not accepted.

Optional Feature:
- ALU_FLAGS_EN defined: zero, negative and overflow are computed and registered as above.
- ALU_FLAGS_EN undefined: flags is tied to 3'b000 and the flag logic is not built. cout is unaffected.

Decomposition:
- Shared package alu_pkg holds:
  - the opcode localparams (OP_INC, OP_ADD, OP_SUB, OP_DEC, OP_AND, OP_OR, OP_XOR, OP_NOT);
  - the FSM state encoding (S_IDLE, S_BUSY, S_DONE).
- One sub-module, alu_digit_slice: combinational, DIGIT-wide.
  - Inputs: a_d, b_d, op, carry_in. Outputs: f_d, carry_out.
  - Implements all 8 ops; B is inverted internally for SUB and forced to all-ones for DEC.
  - Instantiated once in the top and multiplexed over the digit index.

Test Plan:
- WIDTH=16, DIGIT=4, ADD a=0x7FFF b=0x0001 cin=0 -> out_valid 4 clocks after accept; result=0x8000, cout=0, flags={1,1,0}.
- SUB a=0x0003 b=0x0005 -> result=0xFFFE, cout=0 (borrow), flags={0,1,0}. SUB a=5 b=5 -> result=0, cout=1, zero=1.
- INC a=0xFFFF -> result=0x0000, cout=1, zero=1. DEC a=0x8000 -> result=0x7FFF, overflow=1.
- XOR a=0xF0F0 b=0xFF00 -> result=0x0FF0. NOT a=0x00FF -> result=0xFF00, cout=0. in_valid held in BUSY does not trigger a second accept.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> result and flags stable, in_ready=0. out_ready=1 -> IDLE the next cycle, in_ready=1.
- Assert rst on the 2nd BUSY cycle -> next edge gives out_valid=0, result=0, in_ready=1; a fresh ADD 1+1 then returns 2.
